// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter_if
// Purpose  : Writeback request, register-file write and bypass query bundle
//            shared between the writeback requesters and rf_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if #(
  parameter int dataWidth    = 32,
  parameter int AddressWidth = 5
);
  logic                    aluValid;
  logic                    aluReady;
  logic [AddressWidth-1:0] aluRegW;
  logic [dataWidth-1:0]    aluData;
  logic                    memValid;
  logic                    memReady;
  logic [AddressWidth-1:0] memRegW;
  logic [dataWidth-1:0]    memData;
  logic                    hold;
  logic                    RFwrite;
  logic [AddressWidth-1:0] RegW;
  logic [dataWidth-1:0]    dataW;
  logic [AddressWidth-1:0] qRegA;
  logic [AddressWidth-1:0] qRegB;
  logic                    qHitA;
  logic                    qHitB;
  logic [dataWidth-1:0]    qDataA;
  logic [dataWidth-1:0]    qDataB;

  // Requester / decode side
  modport master (
    output aluValid, aluRegW, aluData,
    output memValid, memRegW, memData,
    output hold, qRegA, qRegB,
    input  aluReady, memReady,
    input  RFwrite, RegW, dataW,
    input  qHitA, qHitB, qDataA, qDataB
  );

  // Arbiter side
  modport slave (
    input  aluValid, aluRegW, aluData,
    input  memValid, memRegW, memData,
    input  hold, qRegA, qRegB,
    output aluReady, memReady,
    output RFwrite, RegW, dataW,
    output qHitA, qHitB, qDataA, qDataB
  );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Round-robin arbiter sharing the register-file write port between
//            ALU and load writeback, with a one-entry commit stage and bypass.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int dataWidth    = 32,
  parameter int AddressWidth = 5
) (
  input  logic              Clk,
  input  logic              reset,
  rf_wb_arbiter_if.slave    bus
);

  localparam logic [AddressWidth-1:0] c_regZero  = '0;
  localparam logic [dataWidth-1:0]    c_dataZero = '0;

  logic                    r_stgValid;
  logic [AddressWidth-1:0] r_stgRegW;
  logic [dataWidth-1:0]    r_stgData;
  logic                    r_rrMem;

  logic                    w_aluGrant;
  logic                    w_memGrant;
  logic                    w_xfer;
  logic [AddressWidth-1:0] w_winRegW;
  logic [dataWidth-1:0]    w_winData;
  logic                    w_hitA;
  logic                    w_hitB;

  // Loser of a contended cycle waits; the pointer decides only when both ask.
  always_comb begin
    w_aluGrant = 1'b0;
    w_memGrant = 1'b0;
    if (!bus.hold) begin
      w_aluGrant = bus.aluValid & (~bus.memValid | ~r_rrMem);
      w_memGrant = bus.memValid & (~bus.aluValid |  r_rrMem);
    end
  end

  assign w_xfer    = w_aluGrant | w_memGrant;
  assign w_winRegW = w_memGrant ? bus.memRegW : bus.aluRegW;
  assign w_winData = w_memGrant ? bus.memData : bus.aluData;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_stgValid <= 1'b0;
      r_stgRegW  <= c_regZero;
      r_stgData  <= c_dataZero;
      r_rrMem    <= 1'b0;
    end else begin
      // x0 writes complete the handshake but never reach the register file
      r_stgValid <= w_xfer & (w_winRegW != c_regZero);
      if (w_xfer && (w_winRegW != c_regZero)) begin
        r_stgRegW <= w_winRegW;
        r_stgData <= w_winData;
      end
      if (w_xfer) begin
        r_rrMem <= w_aluGrant;
      end
    end
  end

  assign w_hitA = r_stgValid & (bus.qRegA == r_stgRegW) & (bus.qRegA != c_regZero);
  assign w_hitB = r_stgValid & (bus.qRegB == r_stgRegW) & (bus.qRegB != c_regZero);

  assign bus.aluReady = w_aluGrant;
  assign bus.memReady = w_memGrant;
  assign bus.RFwrite  = r_stgValid;
  assign bus.RegW     = r_stgRegW;
  assign bus.dataW    = r_stgData;
  assign bus.qHitA    = w_hitA;
  assign bus.qHitB    = w_hitB;
  assign bus.qDataA   = w_hitA ? r_stgData : c_dataZero;
  assign bus.qDataB   = w_hitB ? r_stgData : c_dataZero;

endmodule
`default_nettype wire
